router_output_channel: RTL and testbench

- Transmit end of the inter-router link; drives `send`/`data_in` of the downstream router's input channel.
- Accepts 64-bit flits from the local crossbar into one of two virtual channels (VC0 even, VC1 odd), selected by the global `polarity` bit.
- Drains the opposite-polarity VC onto the link, gated by the downstream `ready`.
- The crossbar writes one VC while the link drains the other, so the two never contend.

---
 rtl/router_output_channel.sv | 149 ++++++++++++++
 tb/tb_router_output_channel.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/router_output_channel.sv
// Transmit side of the inter-router link: two polarity-selected virtual-channel FIFOs, written by the crossbar and drained onto the link.
// Optional build macro ROUTER_OC_STATS_EN adds the flits_sent / stall_cycles counters.

module router_oc_vc_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0] count;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (push && !pop)
            count <= count + CNT_W'(1);
        else if (pop && !push)
            count <= count - CNT_W'(1);
    end

    generate
        if (DEPTH == 1) begin : g_single
            // A single entry needs no pointers: the slot is always the head.
            logic [DATA_W-1:0] mem;
            always_ff @(posedge clk) begin
                if (push)
                    mem <= push_data;
            end
            assign head = mem;
        end else begin : g_ring
            localparam int PTR_W = $clog2(DEPTH);
            logic [DATA_W-1:0] mem [DEPTH];
            logic [PTR_W-1:0]  wr_ptr;
            logic [PTR_W-1:0]  rd_ptr;

            // Power-of-2 depth lets the pointers wrap by natural overflow.
            always_ff @(posedge clk) begin
                if (reset) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end else begin
                    if (push) begin
                        mem[wr_ptr] <= push_data;
                        wr_ptr      <= wr_ptr + PTR_W'(1);
                    end
                    if (pop)
                        rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
            assign head = mem[rd_ptr];
        end
    endgenerate
endmodule

module router_output_channel #(
    parameter int VC_DEPTH = 2,
    parameter int DATA_W   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              polarity,
    input  logic              send_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready_out,
    input  logic              ready_in,
    output logic              send_out,
    output logic [DATA_W-1:0] data_out,
    output logic              overflow
`ifdef ROUTER_OC_STATS_EN
    ,
    output logic [31:0]       flits_sent,
    output logic [31:0]       stall_cycles
`endif
);
    logic [1:0]             vc_full;
    logic [1:0]             vc_empty;
    logic [1:0]             vc_push;
    logic [1:0]             vc_pop;
    logic [1:0][DATA_W-1:0] vc_head;
    logic                   rd_vc;
    logic                   pop_any;

    assign rd_vc   = ~polarity;
    assign pop_any = |vc_pop;

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_vc
            // Crossbar writes VC[polarity]; the link drains VC[!polarity].
            assign vc_push[g] = send_in  && !reset && (polarity == 1'(g)) && !vc_full[g];
            assign vc_pop[g]  = ready_in && !reset && (polarity != 1'(g)) && !vc_empty[g];

            router_oc_vc_fifo #(
                .DEPTH (VC_DEPTH),
                .DATA_W(DATA_W)
            ) u_fifo (
                .clk      (clk),
                .reset    (reset),
                .push     (vc_push[g]),
                .push_data(data_in),
                .pop      (vc_pop[g]),
                .head     (vc_head[g]),
                .full     (vc_full[g]),
                .empty    (vc_empty[g])
            );
        end
    endgenerate

    assign ready_out = !vc_full[polarity] && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            send_out <= 1'b0;
            data_out <= '0;
            overflow <= 1'b0;
        end else begin
            send_out <= pop_any;
            data_out <= pop_any ? vc_head[rd_vc] : '0;
            if (send_in && vc_full[polarity])
                overflow <= 1'b1;
        end
    end

`ifdef ROUTER_OC_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            flits_sent   <= '0;
            stall_cycles <= '0;
        end else begin
            if (pop_any && flits_sent != 32'hFFFF_FFFF)
                flits_sent <= flits_sent + 32'd1;
            if (!vc_empty[rd_vc] && !ready_in && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_router_output_channel.sv
// Bench for router_output_channel: directed vector table plus randomized traffic against a queue-based model.
module tb_router_output_channel;
    localparam int VC_DEPTH = 2;
    localparam int DATA_W   = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              polarity = 1'b0;
    logic              send_in = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              ready_out;
    logic              ready_in = 1'b0;
    logic              send_out;
    logic [DATA_W-1:0] data_out;
    logic              overflow;
`ifdef ROUTER_OC_STATS_EN
    logic [31:0]       flits_sent;
    logic [31:0]       stall_cycles;
`endif

    router_output_channel #(.VC_DEPTH(VC_DEPTH), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .send_in  (send_in),
        .data_in  (data_in),
        .ready_out(ready_out),
        .ready_in (ready_in),
        .send_out (send_out),
        .data_out (data_out),
        .overflow (overflow)
`ifdef ROUTER_OC_STATS_EN
        ,
        .flits_sent  (flits_sent),
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r, p, s;
        logic [63:0] d;
        logic        rd;
        logic        e_ro, e_send;
        logic [63:0] e_data;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    logic ro_pre;

    // Reference model: one queue per virtual channel.
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic        m_send = 1'b0;
    logic [63:0] m_data = '0;
    logic        m_ovf  = 1'b0;
    logic [31:0] m_sent = '0;
    logic [31:0] m_stall = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, p, s, input logic [63:0] d, input logic rd,
                       input logic e_ro, e_send, input logic [63:0] e_data, input logic e_ovf);
        vec_t v;
        v.r = r; v.p = p; v.s = s; v.d = d; v.rd = rd;
        v.e_ro = e_ro; v.e_send = e_send; v.e_data = e_data; v.e_ovf = e_ovf;
        tbl.push_back(v);
    endtask

    task automatic model_edge(input logic r, p, s, input logic [63:0] d, input logic rd);
        int rsz, wsz;
        if (r) begin
            q0.delete(); q1.delete();
            m_send = 1'b0; m_data = '0; m_ovf = 1'b0; m_sent = '0; m_stall = '0;
        end else begin
            rsz = p ? q0.size() : q1.size();
            wsz = p ? q1.size() : q0.size();
            if (!rd && rsz > 0 && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (rd && rsz > 0) begin
                m_send = 1'b1;
                m_data = p ? q0.pop_front() : q1.pop_front();
                if (m_sent != 32'hFFFF_FFFF) m_sent++;
            end else begin
                m_send = 1'b0;
                m_data = '0;
            end
            if (s) begin
                if (wsz < VC_DEPTH) begin
                    if (p) q1.push_back(d); else q0.push_back(d);
                end else
                    m_ovf = 1'b1;
            end
        end
    endtask

    // One clock: drive inputs, check combinational ready, clock, check registered outputs.
    task automatic apply(input logic r, p, s, input logic [63:0] d, input logic rd);
        logic exp_ro;
        reset = r; polarity = p; send_in = s; data_in = d; ready_in = rd;
        #1;
        exp_ro = !r && ((p ? q1.size() : q0.size()) < VC_DEPTH);
        ro_pre = ready_out;
        chk($sformatf("model ready_out c%0d", cyc), {63'd0, ro_pre}, {63'd0, exp_ro});
        @(posedge clk);
        model_edge(r, p, s, d, rd);
        #1;
        chk($sformatf("model send_out c%0d", cyc), {63'd0, send_out}, {63'd0, m_send});
        chk($sformatf("model data_out c%0d", cyc), data_out, m_data);
        chk($sformatf("model overflow c%0d", cyc), {63'd0, overflow}, {63'd0, m_ovf});
`ifdef ROUTER_OC_STATS_EN
        chk($sformatf("model flits_sent c%0d", cyc), {32'd0, flits_sent}, {32'd0, m_sent});
        chk($sformatf("model stall_cycles c%0d", cyc), {32'd0, stall_cycles}, {32'd0, m_stall});
`endif
        cyc++;
    endtask

    initial begin
        logic p;
        logic [63:0] d;

        // reset 3 cycles, then release
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0);
        // single flit latency
        add(0, 0, 1, 64'hA5A5_0000_0000_0001, 1, 1, 0, 0, 0);
        add(0, 1, 0, 0, 1, 1, 1, 64'hA5A5_0000_0000_0001, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0);
        // fill VC0, overflow on third write, then drain in order
        add(0, 0, 1, 64'h11, 0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 1, 64'h22, 0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 1, 64'h33, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 1, 1, 1, 64'h11, 1);
        add(0, 0, 0, 0, 1, 1, 0, 0, 1);
        add(0, 1, 0, 0, 1, 1, 1, 64'h22, 1);
        add(0, 0, 0, 0, 1, 1, 0, 0, 1);
        // alternating polarity, back-to-back
        add(0, 0, 1, 64'h1, 1, 1, 0, 0, 1);
        add(0, 1, 1, 64'h2, 1, 1, 1, 64'h1, 1);
        add(0, 0, 1, 64'h3, 1, 1, 1, 64'h2, 1);
        add(0, 1, 1, 64'h4, 1, 1, 1, 64'h3, 1);
        add(0, 0, 0, 0, 1, 1, 1, 64'h4, 1);
        add(0, 1, 0, 0, 1, 1, 0, 0, 1);
        // load both VCs, reset discards everything
        add(0, 0, 1, 64'hAA, 0, 1, 0, 0, 1);
        add(0, 1, 1, 64'hBB, 0, 1, 0, 0, 1);
        add(0, 0, 1, 64'hCC, 0, 1, 0, 0, 1);
        add(0, 1, 1, 64'hDD, 0, 1, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(0, 1'(i), 0, 0, 1, 1, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].r, tbl[i].p, tbl[i].s, tbl[i].d, tbl[i].rd);
            chk($sformatf("vec%0d ready_out", i), {63'd0, ro_pre}, {63'd0, tbl[i].e_ro});
            chk($sformatf("vec%0d send_out", i), {63'd0, send_out}, {63'd0, tbl[i].e_send});
            chk($sformatf("vec%0d data_out", i), data_out, tbl[i].e_data);
            chk($sformatf("vec%0d overflow", i), {63'd0, overflow}, {63'd0, tbl[i].e_ovf});
        end

        // randomized traffic, occasional stuck polarity and resets
        p = 1'b0;
        for (int i = 0; i < 400; i++) begin
            p = ($urandom_range(0, 3) == 0) ? p : ~p;
            d = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
            apply(($urandom_range(0, 49) == 0), p, 1'($urandom), d, ($urandom_range(0, 9) < 7));
        end

        // stall then send: 4 stalled edges, 3 flits
        apply(1, 0, 0, 0, 0);
        apply(0, 0, 1, 64'hF1, 0);
        apply(0, 1, 1, 64'hF2, 0);
        apply(0, 0, 1, 64'hF3, 0);
        apply(0, 1, 0, 0, 0);
        apply(0, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 1);
        chk("stat seq data F1", data_out, 64'hF1);
        apply(0, 0, 0, 0, 1);
        chk("stat seq data F2", data_out, 64'hF2);
        apply(0, 1, 0, 0, 1);
        chk("stat seq data F3", data_out, 64'hF3);
`ifdef ROUTER_OC_STATS_EN
        chk("stall_cycles final", {32'd0, stall_cycles}, 64'd4);
        chk("flits_sent final", {32'd0, flits_sent}, 64'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
